stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Routes one valid/ready input stream to one of N output streams, chosen per beat by a select field. This is the inverse of the mux.
- Each output has its own 2-entry FIFO, so a stalled output blocks only beats addressed to it.
- Sits between a single producer and N consumer lanes in the datapath exercises.
- Beats with an out-of-range select are dropped and flagged.

Parameters:
- N, 4, number of output channels (2..16).
- W, 8, data width in bits.
- SW, $clog2(N) (min 1), width of the select field.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept the beat addressed by in_sel.
- in_data  input  W  input payload.
- in_sel  input  SW  destination channel index.
- out_valid  output  N  bit k: channel k FIFO non-empty.
- out_ready  input  N  bit k: channel k consumer accepts.
- out_data  output  N*W  channel k head entry on bits [k*W +: W].
- drop_err  output  1  sticky flag: at least one beat was dropped.
- drop_cnt  output  8  count of dropped beats; saturates at 255.

Behaviour:
- Reset (rst_n low at posedge):
  - All FIFOs are emptied; read/write pointers go to 0.
  - out_valid = 0, drop_err = 0, drop_cnt = 0.
  - out_data = 0, because the storage is cleared.
  - in_ready = 0 while rst_n is low.
  - A reset mid-transfer discards all buffered beats, with no partial delivery.
- Input handshake: a transfer occurs when in_valid && in_ready at posedge.
- in_ready is combinational from in_sel and the FIFO state:
  - If in_sel < N: in_ready = !full[in_sel] || (out_ready[in_sel] && out_valid[in_sel]). Same-cycle pop frees a slot.
  - If in_sel >= N: in_ready = 1, so the beat is accepted and discarded.
  - in_ready must not depend on in_valid.
- Dropped beat (in_sel >= N, handshake occurs):
  - No FIFO is written.
  - drop_err is set.
  - drop_cnt increments, saturating at 255.
  - drop_err clears only on reset.
- Per-channel FIFO k:
  - Depth 2. Wrap-around pointers plus an occupancy count 0..2.
  - Push when a handshake occurs with in_sel == k. Pop when out_valid[k] && out_ready[k].
  - Simultaneous push and pop: occupancy is unchanged, order is preserved.
  - Simultaneous push and pop when full: allowed, occupancy stays 2.
  - Simultaneous push and pop when empty is impossible, because out_valid = 0.
  - out_valid[k] = (occupancy != 0). out_data[k] = storage at the read pointer (registered, not a bypass).
- Latency: a beat accepted at edge t appears on out_valid/out_data in the cycle after edge t (1 cycle). There is no input-to-output combinational path.
- Ordering:
  - Beats to the same channel exit in acceptance order.
  - No ordering is guaranteed across channels.
- Independence: channels are served in parallel. A full channel never lowers in_ready for beats addressed to another channel.
- AXI-style rules:
  - out_valid/out_data stay stable while out_valid && !out_ready.
  - The producer must hold in_data/in_sel stable while in_valid && !in_ready.
- N not a power of two: select codes N..2^SW-1 are the out-of-range drop cases.

Test Plan:
- Basic routing: N=4, W=8, all out_ready=1; send 0x11→sel0, 0x22→sel1, 0x33→sel2, 0x44→sel3 back-to-back. Required: each out_valid[k] pulses for one cycle, one cycle after its beat, carrying the matching data. in_ready stays 1.
- Backpressure and FIFO full: out_ready[2]=0; send 0xA0, 0xA1, 0xA2 to sel2.
  - First two are accepted; in_ready drops to 0 for the third.
  - Raise out_ready[2]: the FIFO pops 0xA0, the third beat is accepted in the same cycle, and output order is A0, A1, A2.
- No head-of-line blocking: channel 2 full with out_ready[2]=0; send 0x55 to sel1. Required: in_ready=1, out_valid[1]=1 next cycle with 0x55, and channel 2 contents unchanged.
- Out-of-range drop: N=3, send 0x77 with sel=3. Required: in_ready=1, no out_valid asserts, drop_err=1, drop_cnt=1. Send 300 such beats: drop_cnt saturates at 255.
- Reset mid-operation: fill channel 0 and channel 3 with two beats each, assert rst_n=0 for one edge. Required: out_valid=0, drop_err=0, drop_cnt=0, and none of the previously buffered beats is delivered after rst_n returns high.
- Random soak: random in_valid/in_sel/out_ready for 10k cycles against a per-channel queue model. Required: no loss, no duplication, per-channel order preserved, and output stability held under stall.

Source files
------------

// File: rtl/stream_demux.sv
// Single valid/ready stream demultiplexed to N lanes by in_sel.
// Each lane has its own 2-deep FIFO; out-of-range selects are dropped and counted.
module stream_demux #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic           drop_err,
  output logic [7:0]     drop_cnt
);

  logic [W-1:0] mem [N][2];
  logic [N-1:0] wptr;
  logic [N-1:0] rptr;
  logic [1:0]   cnt [N];
  logic [N-1:0] full;
  logic [N-1:0] pop;
  logic [N-1:0] push;
  logic         sel_ok;
  logic         drop;

  assign sel_ok = (32'(in_sel) < N);

  always_comb begin
    full      = '0;
    pop       = '0;
    out_valid = '0;
    out_data  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      out_valid[k]       = (cnt[k] != 2'd0);
      full[k]            = (cnt[k] == 2'd2);
      pop[k]             = out_valid[k] && out_ready[k];
      out_data[k*W +: W] = mem[k][rptr[k]];
    end
  end

  // A same-cycle pop frees a slot, so a full lane can still accept.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (!sel_ok) begin
        in_ready = 1'b1;
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          if (32'(in_sel) == k) in_ready = !full[k] || pop[k];
        end
      end
    end
  end

  always_comb begin
    push = '0;
    for (int unsigned k = 0; k < N; k++) begin
      push[k] = in_valid && in_ready && sel_ok && (32'(in_sel) == k);
    end
  end

  assign drop = in_valid && in_ready && !sel_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        cnt[k]    <= 2'd0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (push[k]) begin
          mem[k][wptr[k]] <= in_data;
          wptr[k]         <= ~wptr[k];
        end
        if (pop[k]) rptr[k] <= ~rptr[k];
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      drop_err <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench: a 4-lane instance for routing/backpressure/soak and a
// 3-lane instance whose select code 3 exercises the drop path.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0, a_in_ready;
  logic [7:0]  a_in_data = '0;
  logic [1:0]  a_in_sel = '0;
  logic [3:0]  a_out_valid, a_out_ready = '0;
  logic [31:0] a_out_data;
  logic        a_drop_err;
  logic [7:0]  a_drop_cnt;

  logic        b_in_valid = 1'b0, b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic [2:0]  b_out_valid, b_out_ready = '0;
  logic [23:0] b_out_data;
  logic        b_drop_err;
  logic [7:0]  b_drop_cnt;

  stream_demux #(.N(4), .W(8), .SW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .drop_err(a_drop_err),
    .drop_cnt(a_drop_cnt));

  stream_demux #(.N(3), .W(8), .SW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .drop_err(b_drop_err),
    .drop_cnt(b_drop_cnt));

  int vecs = 0;
  int errs = 0;
  logic [7:0] qa [4][$];
  logic [7:0] qb [3][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops on every output handshake and checks stall stability.
  logic [3:0] a_pv = '0;
  logic [7:0] a_pd [4];
  logic [2:0] b_pv = '0;
  logic [7:0] b_pd [3];

  always @(negedge clk) begin
    if (!rst_n) begin
      a_pv = '0;
      b_pv = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (a_pv[k]) begin
          chk($sformatf("a_stall_valid%0d", k), 32'(a_out_valid[k]), 32'd1);
          chk($sformatf("a_stall_data%0d", k), 32'(a_out_data[k*8 +: 8]), 32'(a_pd[k]));
        end
        if (a_out_valid[k] && a_out_ready[k]) begin
          if (qa[k].size() == 0) chk($sformatf("a_unexpected%0d", k), 32'(a_out_data[k*8 +: 8]), 32'hFFFF_FFFF);
          else chk($sformatf("a_data%0d", k), 32'(a_out_data[k*8 +: 8]), 32'(qa[k].pop_front()));
        end
        a_pv[k] = a_out_valid[k] && !a_out_ready[k];
        a_pd[k] = a_out_data[k*8 +: 8];
      end
      for (int k = 0; k < 3; k++) begin
        if (b_pv[k]) begin
          chk($sformatf("b_stall_valid%0d", k), 32'(b_out_valid[k]), 32'd1);
          chk($sformatf("b_stall_data%0d", k), 32'(b_out_data[k*8 +: 8]), 32'(b_pd[k]));
        end
        if (b_out_valid[k] && b_out_ready[k]) begin
          if (qb[k].size() == 0) chk($sformatf("b_unexpected%0d", k), 32'(b_out_data[k*8 +: 8]), 32'hFFFF_FFFF);
          else chk($sformatf("b_data%0d", k), 32'(b_out_data[k*8 +: 8]), 32'(qb[k].pop_front()));
        end
        b_pv[k] = b_out_valid[k] && !b_out_ready[k];
        b_pd[k] = b_out_data[k*8 +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [7:0] d, input logic [1:0] s, input logic exp_rdy);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_sel   = s;
    @(negedge clk);
    chk("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    if (a_in_valid && a_in_ready) qa[s].push_back(d);
    step();
  endtask

  task automatic b_beat(input logic [7:0] d, input logic [1:0] s);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_sel   = s;
    @(negedge clk);
    chk("b_in_ready", 32'(b_in_ready), 32'd1);
    if (b_in_ready && s < 2'd3) qb[s].push_back(d);
    step();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic took;
    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data", a_out_data, 32'd0);
    chk("rst_a_ready", 32'(a_in_ready), 32'd0);
    chk("rst_b_err", 32'(b_drop_err), 32'd0);
    chk("rst_b_cnt", 32'(b_drop_cnt), 32'd0);
    step();
    rst_n = 1'b1;

    // Basic routing, all lanes ready
    a_out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h11 * (i + 1));
      a_in_sel   = 2'(i);
      @(negedge clk);
      chk("basic_ready", 32'(a_in_ready), 32'd1);
      chk("basic_valid", 32'(a_out_valid), (i == 0) ? 32'd0 : 32'(1 << (i - 1)));
      qa[i].push_back(a_in_data);
      step();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid_last", 32'(a_out_valid), 32'h8);
    step();
    @(negedge clk);
    chk("basic_idle", 32'(a_out_valid), 32'h0);
    step();

    // Backpressure on lane 2, then no head-of-line blocking on lane 1
    a_out_ready = 4'b1011;
    a_beat(8'hA0, 2'd2, 1'b1);
    a_beat(8'hA1, 2'd2, 1'b1);
    a_beat(8'hA2, 2'd2, 1'b0);
    a_in_valid = 1'b0;
    step();
    a_beat(8'h55, 2'd1, 1'b1);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("hol_valid", 32'(a_out_valid), 32'h6);
    chk("hol_lane1", 32'(a_out_data[15:8]), 32'h55);
    chk("hol_lane2_head", 32'(a_out_data[23:16]), 32'hA0);
    step();
    a_beat(8'hA2, 2'd2, 1'b0);
    a_out_ready = 4'hF;
    a_beat(8'hA2, 2'd2, 1'b1);
    a_in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("bp_drained", 32'(qa[2].size()), 32'd0);
    step();

    // Out-of-range drop on the 3-lane instance
    b_out_ready = 3'b111;
    b_beat(8'h77, 2'd3);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("drop_valid", 32'(b_out_valid), 32'd0);
    chk("drop_err", 32'(b_drop_err), 32'd1);
    chk("drop_cnt1", 32'(b_drop_cnt), 32'd1);
    step();
    for (int i = 0; i < 253; i++) b_beat(8'h77, 2'd3);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("drop_cnt254", 32'(b_drop_cnt), 32'd254);
    step();
    b_beat(8'h77, 2'd3);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("drop_cnt255", 32'(b_drop_cnt), 32'd255);
    step();
    for (int i = 0; i < 45; i++) b_beat(8'h77, 2'd3);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("drop_sat", 32'(b_drop_cnt), 32'd255);
    chk("drop_sat_valid", 32'(b_out_valid), 32'd0);
    step();
    b_beat(8'h3C, 2'd2);
    b_in_valid = 1'b0;
    repeat (3) step();

    // Reset with lanes 0 and 3 full
    a_out_ready = 4'h0;
    a_beat(8'hD0, 2'd0, 1'b1);
    a_beat(8'hD1, 2'd0, 1'b1);
    a_beat(8'hE0, 2'd3, 1'b1);
    a_beat(8'hE1, 2'd3, 1'b1);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(a_out_valid), 32'h9);
    step();
    rst_n = 1'b0;
    a_in_sel = 2'd1;
    for (int k = 0; k < 4; k++) qa[k].delete();
    @(negedge clk);
    chk("in_rst_ready", 32'(a_in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(a_out_valid), 32'd0);
    chk("post_rst_data", a_out_data, 32'd0);
    chk("post_rst_err", 32'(b_drop_err), 32'd0);
    chk("post_rst_cnt", 32'(b_drop_cnt), 32'd0);
    a_out_ready = 4'hF;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_idle", 32'(a_out_valid), 32'd0);
    step();

    // Random soak against the per-lane queues
    took = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      a_out_ready = 4'($urandom);
      if (!a_in_valid || took) begin
        a_in_valid = ($urandom_range(0, 3) != 0);
        a_in_data  = 8'($urandom);
        a_in_sel   = 2'($urandom);
      end
      @(negedge clk);
      took = a_in_valid && a_in_ready;
      if (took) qa[a_in_sel].push_back(a_in_data);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 4'hF;
    repeat (5) step();
    for (int k = 0; k < 4; k++) chk($sformatf("soak_left%0d", k), 32'(qa[k].size()), 32'd0);
    for (int k = 0; k < 3; k++) chk($sformatf("b_left%0d", k), 32'(qb[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
